// File: rtl/ahb_master_bridge.sv
// ahb_master_bridge: AHB-Lite master that turns single read/write requests
// (valid/ready) into NONSEQ SINGLE transfers. The address phase of request
// N+1 overlaps the data phase of request N.
//
// Build option: AHB_MASTER_TIMEOUT_EN adds a wait-state watchdog driving
// o_timeout. Without it, o_timeout is tied low.
//
// Ports
//   i_clk_ahb, i_rstn_ahb        : AHB clock, async active-low reset
//   i_valid/o_ready              : request handshake (o_ready combinational)
//   i_rd0_wr1, i_size, i_addr,
//   i_wr_data                    : request payload
//   o_rd_valid/o_rd_data         : read completion pulse and data
//   o_wr_done, o_err             : write OKAY / ERROR completion pulses
//   o_timeout                    : sticky wait-state timeout flag
//   o_h*                         : AHB master outputs
//   i_hready, i_hresp, i_hrdata  : AHB slave responses
module ahb_master_bridge #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR           = 32,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                  i_clk_ahb,
  input  logic                  i_rstn_ahb,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic                  i_rd0_wr1,
  input  logic [2:0]            i_size,
  input  logic [ADDR-1:0]       i_addr,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  output logic                  o_rd_valid,
  output logic [DATA_WIDTH-1:0] o_rd_data,
  output logic                  o_wr_done,
  output logic                  o_err,
  output logic                  o_timeout,
  output logic [1:0]            o_htrans,
  output logic [ADDR-1:0]       o_haddr,
  output logic                  o_hwrite,
  output logic [2:0]            o_hsize,
  output logic [2:0]            o_hburst,
  output logic [3:0]            o_hprot,
  output logic                  o_hmastlock,
  output logic [DATA_WIDTH-1:0] o_hwdata,
  input  logic                  i_hready,
  input  logic                  i_hresp,
  input  logic [DATA_WIDTH-1:0] i_hrdata
);

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  // State bits are {A, D}: address phase on bus, data phase on bus.
  typedef enum logic [1:0] {
    S_IDLE      = 2'b00,
    S_DATA      = 2'b01,
    S_ADDR      = 2'b10,
    S_ADDR_DATA = 2'b11
  } state_t;

  state_t                state_q, state_d;
  logic                  a_q, d_q, a_n, d_n;
  logic                  err_hold_q, err_hold_d;
  logic                  d_write_q, d_write_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic [1:0]            htrans_d;
  logic [ADDR-1:0]       haddr_d;
  logic                  hwrite_d;
  logic [2:0]            hsize_d;
  logic [DATA_WIDTH-1:0] hwdata_d;
  logic                  rd_valid_d, wr_done_d, err_d;
  logic [DATA_WIDTH-1:0] rd_data_d;
  logic                  accept, done, err_first;

  assign a_q = state_q[1];
  assign d_q = state_q[0];

  assign o_hburst    = 3'b000;
  assign o_hprot     = 4'b0011;
  assign o_hmastlock = 1'b0;

  // Pipeline may advance when the address phase is free or being sampled.
  assign o_ready   = (!a_q || i_hready) && !err_hold_q;
  assign accept    = i_valid && o_ready;
  assign done      = d_q && i_hready;
  assign err_first = d_q && i_hresp && !i_hready && !err_hold_q;

  // State register and all registered outputs.
  always_ff @(posedge i_clk_ahb or negedge i_rstn_ahb) begin
    if (!i_rstn_ahb) begin
      state_q    <= S_IDLE;
      err_hold_q <= 1'b0;
      d_write_q  <= 1'b0;
      wr_data_q  <= '0;
      o_htrans   <= HTRANS_IDLE;
      o_haddr    <= '0;
      o_hwrite   <= 1'b0;
      o_hsize    <= 3'b010;
      o_hwdata   <= '0;
      o_rd_valid <= 1'b0;
      o_rd_data  <= '0;
      o_wr_done  <= 1'b0;
      o_err      <= 1'b0;
    end else begin
      state_q    <= state_d;
      err_hold_q <= err_hold_d;
      d_write_q  <= d_write_d;
      wr_data_q  <= wr_data_d;
      o_htrans   <= htrans_d;
      o_haddr    <= haddr_d;
      o_hwrite   <= hwrite_d;
      o_hsize    <= hsize_d;
      o_hwdata   <= hwdata_d;
      o_rd_valid <= rd_valid_d;
      o_rd_data  <= rd_data_d;
      o_wr_done  <= wr_done_d;
      o_err      <= err_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    a_n        = a_q;
    d_n        = d_q;
    err_hold_d = err_hold_q;
    d_write_d  = d_write_q;
    wr_data_d  = wr_data_q;
    htrans_d   = o_htrans;
    haddr_d    = o_haddr;
    hwrite_d   = o_hwrite;
    hsize_d    = o_hsize;
    hwdata_d   = o_hwdata;
    rd_valid_d = 1'b0;
    rd_data_d  = o_rd_data;
    wr_done_d  = 1'b0;
    err_d      = 1'b0;

    if (o_ready) begin
      a_n = accept;
      // Address phase sampled by the slave: it becomes the data phase.
      if (a_q) begin
        hwdata_d  = wr_data_q;
        d_write_d = o_hwrite;
      end
      // A stalled data phase with no address phase must not be dropped.
      if (!d_q || i_hready) d_n = a_q;
      if (accept) begin
        haddr_d   = i_addr;
        hwrite_d  = i_rd0_wr1;
        hsize_d   = i_size;
        wr_data_d = i_wr_data;
      end
      htrans_d = accept ? HTRANS_NONSEQ : HTRANS_IDLE;
    end

    // Two-cycle ERROR: drop to IDLE, then replay any pending address phase.
    if (err_first) begin
      err_hold_d = 1'b1;
      htrans_d   = HTRANS_IDLE;
    end else if (err_hold_q && i_hready) begin
      err_hold_d = 1'b0;
      d_n        = 1'b0;
      htrans_d   = a_q ? HTRANS_NONSEQ : HTRANS_IDLE;
    end

    if (done) begin
      if (i_hresp) begin
        err_d = 1'b1;
      end else if (d_write_q) begin
        wr_done_d = 1'b1;
      end else begin
        rd_valid_d = 1'b1;
        rd_data_d  = i_hrdata;
      end
    end

    state_d = state_t'({a_n, d_n});
  end

`ifdef AHB_MASTER_TIMEOUT_EN
  localparam int unsigned TCW = $clog2(TIMEOUT_CYCLES);

  logic [TCW-1:0] tmo_cnt_q;

  // Counts consecutive stalled data-phase cycles; saturates at the limit.
  always_ff @(posedge i_clk_ahb or negedge i_rstn_ahb) begin
    if (!i_rstn_ahb) begin
      tmo_cnt_q <= '0;
      o_timeout <= 1'b0;
    end else if (d_q && !i_hready) begin
      if (tmo_cnt_q == TCW'(TIMEOUT_CYCLES - 1)) begin
        o_timeout <= 1'b1;
      end else begin
        tmo_cnt_q <= tmo_cnt_q + TCW'(1);
      end
    end else begin
      tmo_cnt_q <= '0;
    end
  end
`else
  // Watchdog not built; the parameter is still referenced to keep it live.
  assign o_timeout = (TIMEOUT_CYCLES < 2) && 1'b0;
`endif

endmodule

// File: tb/tb_ahb_master_bridge.sv
// Testbench for ahb_master_bridge: per-cycle vector table for the main
// transfer scenarios, plus hand-written timeout and reset sequences.
module tb_ahb_master_bridge;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 32;
`ifdef AHB_MASTER_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic          clk, rst_n;
  logic          valid, ready, rd0_wr1;
  logic [2:0]    size;
  logic [AW-1:0] addr;
  logic [DW-1:0] wr_data;
  logic          rd_valid, wr_done, err, timeout;
  logic [DW-1:0] rd_data;
  logic [1:0]    htrans;
  logic [AW-1:0] haddr;
  logic          hwrite, hmastlock;
  logic [2:0]    hsize, hburst;
  logic [3:0]    hprot;
  logic [DW-1:0] hwdata;
  logic          hready, hresp;
  logic [DW-1:0] hrdata;

  int errors = 0;
  int checks = 0;
  int cur    = -1;

  ahb_master_bridge #(
    .DATA_WIDTH     (DW),
    .ADDR           (AW),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .i_clk_ahb   (clk),
    .i_rstn_ahb  (rst_n),
    .i_valid     (valid),
    .o_ready     (ready),
    .i_rd0_wr1   (rd0_wr1),
    .i_size      (size),
    .i_addr      (addr),
    .i_wr_data   (wr_data),
    .o_rd_valid  (rd_valid),
    .o_rd_data   (rd_data),
    .o_wr_done   (wr_done),
    .o_err       (err),
    .o_timeout   (timeout),
    .o_htrans    (htrans),
    .o_haddr     (haddr),
    .o_hwrite    (hwrite),
    .o_hsize     (hsize),
    .o_hburst    (hburst),
    .o_hprot     (hprot),
    .o_hmastlock (hmastlock),
    .o_hwdata    (hwdata),
    .i_hready    (hready),
    .i_hresp     (hresp),
    .i_hrdata    (hrdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        v;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wd;
    logic        hr;
    logic        hresp;
    logic [31:0] hrd;
    logic        e_ready;
    logic [1:0]  e_htrans;
    logic [31:0] e_haddr;
    logic [31:0] e_hwdata;
    logic        e_rdv;
    logic        e_wrd;
    logic        e_err;
    logic [31:0] e_rdata;
  } vec_t;

  function automatic vec_t mk(input logic v, input logic wr, input logic [31:0] a,
                              input logic [31:0] wd, input logic hr, input logic hrsp,
                              input logic [31:0] hrd, input logic e_rdy,
                              input logic [1:0] e_ht, input logic [31:0] e_ha,
                              input logic [31:0] e_hwd, input logic e_rdv,
                              input logic e_wrd, input logic e_err,
                              input logic [31:0] e_rd);
    vec_t r;
    r.v = v; r.wr = wr; r.addr = a; r.wd = wd; r.hr = hr; r.hresp = hrsp; r.hrd = hrd;
    r.e_ready = e_rdy; r.e_htrans = e_ht; r.e_haddr = e_ha; r.e_hwdata = e_hwd;
    r.e_rdv = e_rdv; r.e_wrd = e_wrd; r.e_err = e_err; r.e_rdata = e_rd;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step=%0d actual=0x%0h required=0x%0h", name, cur, act, exp);
    end
  endtask

  // Drive one cycle of inputs, check o_ready before the edge and registered outputs after.
  task automatic run_vec(input vec_t t);
    valid   = t.v;
    rd0_wr1 = t.wr;
    addr    = t.addr;
    wr_data = t.wd;
    hready  = t.hr;
    hresp   = t.hresp;
    hrdata  = t.hrd;
    #1;
    chk("ready", 32'(ready), 32'(t.e_ready));
    @(posedge clk);
    #1;
    chk("htrans",   32'(htrans),   32'(t.e_htrans));
    chk("haddr",    haddr,         t.e_haddr);
    chk("hwdata",   hwdata,        t.e_hwdata);
    chk("rd_valid", 32'(rd_valid), 32'(t.e_rdv));
    chk("wr_done",  32'(wr_done),  32'(t.e_wrd));
    chk("err",      32'(err),      32'(t.e_err));
    chk("rd_data",  rd_data,       t.e_rdata);
  endtask

  task automatic chk_reset_vals();
    chk("rst_htrans",   32'(htrans),   32'h0);
    chk("rst_haddr",    haddr,         32'h0);
    chk("rst_hwrite",   32'(hwrite),   32'h0);
    chk("rst_hsize",    32'(hsize),    32'h2);
    chk("rst_hwdata",   hwdata,        32'h0);
    chk("rst_rd_data",  rd_data,       32'h0);
    chk("rst_pulses",   32'({rd_valid, wr_done, err}), 32'h0);
    chk("rst_timeout",  32'(timeout),  32'h0);
    chk("rst_ready",    32'(ready),    32'h1);
  endtask

  localparam logic [31:0] R1 = 32'h12345678;
  localparam logic [31:0] R2 = 32'hCAFEF00D;

  vec_t tbl[24];
  vec_t tv;

  initial begin
    rst_n = 1'b0; valid = 1'b0; rd0_wr1 = 1'b0; size = 3'b010; addr = '0;
    wr_data = '0; hready = 1'b1; hresp = 1'b0; hrdata = '0;

    // Single write, read with 2 wait states, 4 back-to-back writes, ERROR with pending write.
    tbl[0]  = mk(1,1,32'h100,32'hDEADBEEF,1,0,0,  1,2,32'h100,32'h0,       0,0,0,0);
    tbl[1]  = mk(0,0,0,0,1,0,0,                   1,0,32'h100,32'hDEADBEEF,0,0,0,0);
    tbl[2]  = mk(0,0,0,0,1,0,0,                   1,0,32'h100,32'hDEADBEEF,0,1,0,0);
    tbl[3]  = mk(0,0,0,0,1,0,0,                   1,0,32'h100,32'hDEADBEEF,0,0,0,0);
    tbl[4]  = mk(1,0,32'h200,0,1,0,0,             1,2,32'h200,32'hDEADBEEF,0,0,0,0);
    tbl[5]  = mk(0,0,0,0,1,0,0,                   1,0,32'h200,32'h0,       0,0,0,0);
    tbl[6]  = mk(0,0,0,0,0,0,0,                   1,0,32'h200,32'h0,       0,0,0,0);
    tbl[7]  = mk(0,0,0,0,0,0,0,                   1,0,32'h200,32'h0,       0,0,0,0);
    tbl[8]  = mk(0,0,0,0,1,0,R1,                  1,0,32'h200,32'h0,       1,0,0,R1);
    tbl[9]  = mk(0,0,0,0,1,0,0,                   1,0,32'h200,32'h0,       0,0,0,R1);
    tbl[10] = mk(1,1,32'h0,32'h11,1,0,0,          1,2,32'h0,  32'h0,       0,0,0,R1);
    tbl[11] = mk(1,1,32'h4,32'h22,1,0,0,          1,2,32'h4,  32'h11,      0,0,0,R1);
    tbl[12] = mk(1,1,32'h8,32'h33,1,0,0,          1,2,32'h8,  32'h22,      0,1,0,R1);
    tbl[13] = mk(1,1,32'hC,32'h44,1,0,0,          1,2,32'hC,  32'h33,      0,1,0,R1);
    tbl[14] = mk(0,0,0,0,1,0,0,                   1,0,32'hC,  32'h44,      0,1,0,R1);
    tbl[15] = mk(0,0,0,0,1,0,0,                   1,0,32'hC,  32'h44,      0,1,0,R1);
    tbl[16] = mk(0,0,0,0,1,0,0,                   1,0,32'hC,  32'h44,      0,0,0,R1);
    tbl[17] = mk(1,0,32'h300,0,1,0,0,             1,2,32'h300,32'h44,      0,0,0,R1);
    tbl[18] = mk(1,1,32'h304,32'h55,1,0,0,        1,2,32'h304,32'h0,       0,0,0,R1);
    tbl[19] = mk(0,0,0,0,0,1,0,                   0,0,32'h304,32'h0,       0,0,0,R1);
    tbl[20] = mk(0,0,0,0,1,1,0,                   0,2,32'h304,32'h0,       0,0,1,R1);
    tbl[21] = mk(0,0,0,0,1,0,0,                   1,0,32'h304,32'h55,      0,0,0,R1);
    tbl[22] = mk(0,0,0,0,1,0,0,                   1,0,32'h304,32'h55,      0,1,0,R1);
    tbl[23] = mk(0,0,0,0,1,0,0,                   1,0,32'h304,32'h55,      0,0,0,R1);

    #12;
    chk_reset_vals();
    chk("hburst",    32'(hburst),    32'h0);
    chk("hprot",     32'(hprot),     32'h3);
    chk("hmastlock", 32'(hmastlock), 32'h0);
    #10;
    rst_n = 1'b1;

    for (int i = 0; i < 24; i++) begin
      cur = i;
      run_vec(tbl[i]);
    end

    // Read 0x500 then stall its data phase for 10 cycles.
    cur = 100;
    run_vec(mk(1,0,32'h500,0,1,0,0, 1,2,32'h500,32'h55,0,0,0,R1));
    run_vec(mk(0,0,0,0,1,0,0,       1,0,32'h500,32'h0, 0,0,0,R1));
    for (int k = 1; k <= 10; k++) begin
      cur = 100 + k;
      run_vec(mk(0,0,0,0,0,0,0, 1,0,32'h500,32'h0,0,0,0,R1));
      chk("timeout", 32'(timeout), 32'(TMO_EN && (k >= 8)));
    end
    cur = 111;
    run_vec(mk(0,0,0,0,1,0,R2, 1,0,32'h500,32'h0,1,0,0,R2));
    chk("timeout_sticky", 32'(timeout), 32'(TMO_EN));

    // Reset while in ADDR_DATA: outputs return to reset values at once, no pulses follow.
    cur = 200;
    run_vec(mk(1,1,32'h400,32'h66,1,0,0, 1,2,32'h400,32'h0, 0,0,0,R2));
    run_vec(mk(1,1,32'h404,32'h77,1,0,0, 1,2,32'h404,32'h66,0,0,0,R2));
    valid = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    chk_reset_vals();
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cur = 210 + k;
      run_vec(mk(0,0,0,0,1,0,0, 1,0,32'h0,32'h0,0,0,0,0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
